wifi_frame_uart_tx: RTL and testbench

//   Downstream stage of the J1 WiFi communications peripheral. Takes the

---
 rtl/wifi_frame_pkg.sv | 32 +++
 rtl/uart_tx_byte.sv | 101 ++++++++++
 rtl/wifi_frame_uart_tx.sv | 124 ++++++++++++
 tb/tb_wifi_frame_uart_tx.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/wifi_frame_pkg.sv
// Package: wifi_frame_pkg
// Purpose: Shared constants and types for the WiFi frame UART transmitter:
//          default SOF/EOF bytes, the byte-level UART state encoding, the
//          frame byte indices and the number of bytes per frame.
// Configuration: WIFI_FRAME_CHECKSUM_EN adds a checksum byte (NBYTES=5);
//                otherwise frames are 4 bytes.
package wifi_frame_pkg;

    localparam logic [7:0] SOF_DEFAULT = 8'h7E;
    localparam logic [7:0] EOF_DEFAULT = 8'h0A;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

    localparam logic [2:0] IDX_SOF  = 3'd0;
    localparam logic [2:0] IDX_CMD  = 3'd1;
    localparam logic [2:0] IDX_DATA = 3'd2;

`ifdef WIFI_FRAME_CHECKSUM_EN
    localparam logic [2:0] IDX_CHK  = 3'd3;
    localparam logic [2:0] IDX_EOF  = 3'd4;
    localparam int         NBYTES   = 5;
`else
    localparam logic [2:0] IDX_EOF  = 3'd3;
    localparam int         NBYTES   = 4;
`endif

endpackage

// File: rtl/uart_tx_byte.sv
// Module: uart_tx_byte
// Purpose: Sends one byte as UART 8N1 (start 0, 8 data bits LSB first,
//          stop 1), each bit held BAUD_DIV clocks.
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-high reset
//   load      in   start a byte; honoured in IDLE or on the last stop-bit clock
//   byte_in   in   byte to send, captured when load is honoured
//   tx        out  serial line, idle high
//   byte_done out  high on the last clock of the stop bit
//
// state | meaning
// IDLE  | line high, waiting for load
// START | driving start bit (0)
// DATA  | driving data bit bit_cnt (0..7), LSB first
// STOP  | driving stop bit (1); a load here chains the next byte gap-free
module uart_tx_byte
    import wifi_frame_pkg::*;
#(
    parameter int BAUD_DIV = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [7:0] byte_in,
    output logic       tx,
    output logic       byte_done
);

    localparam int                CNT_W     = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
    localparam logic [CNT_W-1:0]  BAUD_LAST = CNT_W'(BAUD_DIV - 1);

    tx_state_e        state_q, state_d;
    logic [CNT_W-1:0] baud_cnt_q, baud_cnt_d;
    logic [2:0]       bit_cnt_q, bit_cnt_d;
    logic [7:0]       shift_q, shift_d;
    logic             bit_end;

    assign bit_end   = (baud_cnt_q == BAUD_LAST);
    assign byte_done = (state_q == STOP) && bit_end;

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        shift_d    = shift_q;
        baud_cnt_d = (bit_end || state_q == IDLE) ? '0 : baud_cnt_q + CNT_W'(1);
        tx         = 1'b1;

        case (state_q)
            IDLE: begin
                if (load) begin
                    state_d = START;
                    shift_d = byte_in;
                end
            end
            START: begin
                tx = 1'b0;
                if (bit_end) begin
                    state_d   = DATA;
                    bit_cnt_d = 3'd0;
                end
            end
            DATA: begin
                tx = shift_q[0];
                if (bit_end) begin
                    shift_d   = {1'b0, shift_q[7:1]};
                    bit_cnt_d = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    if (load) begin
                        state_d = START;
                        shift_d = byte_in;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            baud_cnt_q <= '0;
            bit_cnt_q  <= '0;
            shift_q    <= '0;
        end else begin
            state_q    <= state_d;
            baud_cnt_q <= baud_cnt_d;
            bit_cnt_q  <= bit_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/wifi_frame_uart_tx.sv
// Module: wifi_frame_uart_tx
// Purpose: Frames a command/data pair as SOF, CMD, DATA, [CHK], EOF and
//          sends it over UART 8N1 to the WiFi module.
// Ports:
//   clk      in   system clock
//   rst      in   synchronous active-high reset
//   datos    in   payload data byte
//   comando  in   command byte
//   init     in   start request (level, accepted when not busy)
//   tx       out  UART line, idle high
//   bussy    out  high while a frame is in flight
//   done     out  one-cycle pulse after the last EOF stop-bit clock
// Configuration: WIFI_FRAME_CHECKSUM_EN inserts CHK = comando ^ datos
//                between DATA and EOF.
module wifi_frame_uart_tx
    import wifi_frame_pkg::*;
#(
    parameter int         CLK_HZ   = 50_000_000,
    parameter int         BAUD     = 115200,
    parameter int         BAUD_DIV = CLK_HZ / BAUD,
    parameter logic [7:0] SOF      = SOF_DEFAULT,
    parameter logic [7:0] EOF      = EOF_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] datos,
    input  logic [7:0] comando,
    input  logic       init,
    output logic       tx,
    output logic       bussy,
    output logic       done
);

    if (BAUD_DIV < 2) begin : g_bad_baud_div
        $error("wifi_frame_uart_tx: BAUD_DIV must be >= 2");
    end

    logic [7:0] cmd_q, cmd_d;
    logic [7:0] dat_q, dat_d;
    logic [2:0] byte_idx_q, byte_idx_d;
    logic       bussy_q, bussy_d;
    logic       done_q, done_d;

    logic       accept;
    logic       more;
    logic       last;
    logic       load;
    logic       byte_done;
    logic [2:0] next_idx;
    logic [7:0] byte_sel;

    assign accept = init && !bussy_q;
    assign more   = byte_done && (byte_idx_q < 3'(NBYTES - 1));
    assign last   = byte_done && !more;
    assign load   = accept || more;

    // SOF is a constant, so selecting it on the accept edge does not need
    // the shadow registers that are only being written on that same edge.
    always_comb begin
        next_idx = accept ? IDX_SOF : byte_idx_q + 3'd1;
        case (next_idx)
            IDX_SOF:  byte_sel = SOF;
            IDX_CMD:  byte_sel = cmd_q;
            IDX_DATA: byte_sel = dat_q;
`ifdef WIFI_FRAME_CHECKSUM_EN
            IDX_CHK:  byte_sel = cmd_q ^ dat_q;
`endif
            IDX_EOF:  byte_sel = EOF;
            default:  byte_sel = EOF;
        endcase
    end

    always_comb begin
        cmd_d      = cmd_q;
        dat_d      = dat_q;
        byte_idx_d = byte_idx_q;
        bussy_d    = bussy_q;
        done_d     = 1'b0;

        if (accept) begin
            cmd_d      = comando;
            dat_d      = datos;
            byte_idx_d = IDX_SOF;
            bussy_d    = 1'b1;
        end else if (more) begin
            byte_idx_d = byte_idx_q + 3'd1;
        end else if (last) begin
            byte_idx_d = IDX_SOF;
            bussy_d    = 1'b0;
            done_d     = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cmd_q      <= '0;
            dat_q      <= '0;
            byte_idx_q <= '0;
            bussy_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            cmd_q      <= cmd_d;
            dat_q      <= dat_d;
            byte_idx_q <= byte_idx_d;
            bussy_q    <= bussy_d;
            done_q     <= done_d;
        end
    end

    uart_tx_byte #(
        .BAUD_DIV (BAUD_DIV)
    ) u_byte (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .byte_in   (byte_sel),
        .tx        (tx),
        .byte_done (byte_done)
    );

    assign bussy = bussy_q;
    assign done  = done_q;

endmodule

// File: tb/tb_wifi_frame_uart_tx.sv
module tb_wifi_frame_uart_tx;

    localparam int BD = 4;
`ifdef WIFI_FRAME_CHECKSUM_EN
    localparam int NB = 5;
`else
    localparam int NB = 4;
`endif
    localparam int FRAME_CYC = NB * 10 * BD;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] datos;
    logic [7:0] comando;
    logic       init;
    logic       tx;
    logic       bussy;
    logic       done;

    wifi_frame_uart_tx #(
        .CLK_HZ (400),
        .BAUD   (100)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .datos   (datos),
        .comando (comando),
        .init    (init),
        .tx      (tx),
        .bussy   (bussy),
        .done    (done)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] cmd;
        logic [7:0] dat;
        logic [7:0] chk;
        bit         disturb;
    } vec_t;

    vec_t       vecs [4];
    int         total = 0;
    int         bad   = 0;
    int         done_cnt = 0;
    logic       smp [0:FRAME_CYC-1];
    logic [7:0] got [0:4];

    always @(negedge clk) if (done === 1'b1) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [7:0] exp_byte(input int k, input logic [7:0] c,
                                             input logic [7:0] d, input logic [7:0] x);
        case (k)
            0: return 8'h7E;
            1: return c;
            2: return d;
`ifdef WIFI_FRAME_CHECKSUM_EN
            3: return x;
`endif
            default: return 8'h0A;
        endcase
    endfunction

    task automatic wait_start();
        int n = 0;
        while (tx !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", tx, 1'b0);
    endtask

    // Called at the negedge of the first start-bit cycle; returns at the
    // negedge of the done cycle.
    task automatic capture_body();
        int hold_err  = 0;
        int bussy_err = 0;
        int frame_err = 0;
        for (int c = 0; c < FRAME_CYC; c++) begin
            smp[c] = tx;
            if (bussy !== 1'b1) bussy_err++;
            @(negedge clk);
        end
        check("done_pulse", done, 1'b1);
        check("bussy_at_done", bussy, 1'b0);
        check("tx_idle_at_done", tx, 1'b1);
        for (int k = 0; k < NB; k++) begin
            got[k] = 8'h00;
            for (int b = 0; b < 10; b++) begin
                int base = (k * 10 + b) * BD;
                for (int j = 1; j < BD; j++)
                    if (smp[base + j] !== smp[base]) hold_err++;
                if (b >= 1 && b <= 8) got[k][b-1] = smp[base];
            end
            if (smp[k * 10 * BD] !== 1'b0) frame_err++;
            if (smp[(k * 10 + 9) * BD] !== 1'b1) frame_err++;
        end
        check("bit_hold", hold_err, 0);
        check("bussy_len", bussy_err, 0);
        check("framing", frame_err, 0);
    endtask

    task automatic check_bytes(input logic [7:0] c, input logic [7:0] d, input logic [7:0] x);
        for (int k = 0; k < NB; k++)
            check($sformatf("byte%0d", k), got[k], exp_byte(k, c, d, x));
    endtask

    task automatic idle_check(input int n, input string name);
        int tx_low = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || bussy !== 1'b0) tx_low++;
        end
        check(name, tx_low, 0);
    endtask

    task automatic pulse_init(input logic [7:0] c, input logic [7:0] d);
        comando = c;
        datos   = d;
        init    = 1'b1;
        @(negedge clk);
        init    = 1'b0;
    endtask

    initial begin
        int dc;
        vecs[0] = '{cmd: 8'h41, dat: 8'h35, chk: 8'h74, disturb: 1'b0};
        vecs[1] = '{cmd: 8'h41, dat: 8'h35, chk: 8'h74, disturb: 1'b1};
        vecs[2] = '{cmd: 8'hA5, dat: 8'h5A, chk: 8'hFF, disturb: 1'b0};
        vecs[3] = '{cmd: 8'hFF, dat: 8'h80, chk: 8'h7F, disturb: 1'b0};

        rst = 1'b1; init = 1'b0; comando = 8'h00; datos = 8'h00;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_tx", tx, 1'b1);
        check("rst_bussy", bussy, 1'b0);
        check("rst_done", done, 1'b0);
        idle_check(100, "rst_quiet");
        check("rst_done_cnt", done_cnt, 0);

        for (int v = 0; v < 4; v++) begin
            dc = done_cnt;
            pulse_init(vecs[v].cmd, vecs[v].dat);
            wait_start();
            fork
                capture_body();
                begin
                    if (vecs[v].disturb) begin
                        repeat (50) @(negedge clk);
                        comando = 8'hFF;
                        datos   = 8'h00;
                        init    = 1'b1;
                        @(negedge clk);
                        init    = 1'b0;
                    end
                end
            join
            check_bytes(vecs[v].cmd, vecs[v].dat, vecs[v].chk);
            idle_check(60, "no_extra_frame");
            check("done_count", done_cnt - dc, 1);
        end

        dc = done_cnt;
        comando = 8'h01; datos = 8'h02; init = 1'b1;
        @(negedge clk);
        wait_start();
        capture_body();
        check_bytes(8'h01, 8'h02, 8'h03);
        @(negedge clk);
        check("b2b_start", tx, 1'b0);
        init = 1'b0;
        capture_body();
        check_bytes(8'h01, 8'h02, 8'h03);
        idle_check(60, "b2b_stop");
        check("b2b_done_count", done_cnt - dc, 2);

        dc = done_cnt;
        pulse_init(8'h41, 8'h35);
        wait_start();
        repeat (57) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("midrst_tx", tx, 1'b1);
        check("midrst_bussy", bussy, 1'b0);
        check("midrst_done", done, 1'b0);
        idle_check(50, "midrst_quiet");
        check("midrst_no_done", done_cnt - dc, 0);
        pulse_init(8'h3C, 8'hC3);
        wait_start();
        capture_body();
        check_bytes(8'h3C, 8'hC3, 8'hFF);
        idle_check(20, "after_rst_idle");
        check("after_rst_done", done_cnt - dc, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
